// File: rtl/lbp_pkg.sv
// lbp_pkg: shared constants and types for the LBP histogram stage.
//   CODE_W    : LBP code width (bin index width)
//   BINS      : number of histogram bins (2^CODE_W)
//   IMG_W     : frame edge length in pixels
//   INNER_PIX : codes produced per frame (interior of the frame)
//   CNT_W     : bin counter width, just wide enough for INNER_PIX
//   ADDR_W    : pixel address width {row,col}
package lbp_pkg;

  localparam int CODE_W    = 8;
  localparam int BINS      = 1 << CODE_W;
  localparam int IMG_W     = 128;
  localparam int INNER_PIX = (IMG_W - 2) * (IMG_W - 2);
  localparam int CNT_W     = $clog2(INNER_PIX + 1);
  localparam int ADDR_W    = $clog2(IMG_W * IMG_W);

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    DRAIN = 2'd1,
    OUT   = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/lbp_hist_ram.sv
// lbp_hist_ram: BINS x CNT_W bin storage, one synchronous read port with
// one-cycle latency and one write port. On a same-address read/write in one
// cycle the read returns the old contents.
//   clk     : clock
//   rd_en   : launch a read of rd_addr; rdata holds while rd_en is low
//   rd_addr : read bin index
//   rdata   : read data, valid the cycle after rd_en
//   wr_en   : write wdata to wr_addr
//   wr_addr : write bin index
//   wdata   : write data
module lbp_hist_ram
  import lbp_pkg::*;
(
  input  logic              clk,
  input  logic              rd_en,
  input  logic [CODE_W-1:0] rd_addr,
  output logic [CNT_W-1:0]  rdata,
  input  logic              wr_en,
  input  logic [CODE_W-1:0] wr_addr,
  input  logic [CNT_W-1:0]  wdata
);

  logic [CNT_W-1:0] mem [BINS];

  always_ff @(posedge clk) begin
    if (rd_en) rdata <= mem[rd_addr];
    if (wr_en) mem[wr_addr] <= wdata;
  end

endmodule

// File: rtl/lbp_hist.sv
// lbp_hist: accumulates a histogram of LBP codes over one frame, then streams
// the bin counts out in ascending order over a valid/ready handshake.
//   clk        : clock
//   reset      : synchronous active-high reset
//   lbp_valid  : lbp_data/lbp_addr valid this cycle
//   lbp_addr   : pixel address {row,col} (not needed: one valid = one code)
//   lbp_data   : LBP code, used as the bin index
//   finish     : level from upstream; rising edge ends accumulation
//   clear      : one-cycle pulse, empties the histogram and re-arms
//   hist_bin   : bin index of the current output beat
//   hist_count : count of that bin
//   hist_valid : output beat valid
//   hist_ready : downstream accepts the beat
//   pix_cnt    : codes accumulated this frame
//   hist_done  : all bins delivered; held until clear or reset
//
// state | meaning
// ACCUM | counting incoming codes into the bin RAM
// DRAIN | last in-flight increment retires
// OUT   | streaming bins; read issued while hist_valid=0, beat shown next cycle
// DONE  | all bins delivered, waiting for clear
module lbp_hist
  import lbp_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              lbp_valid,
  input  logic [ADDR_W-1:0] lbp_addr,
  input  logic [CODE_W-1:0] lbp_data,
  input  logic              finish,
  input  logic              clear,
  output logic [CODE_W-1:0] hist_bin,
  output logic [CNT_W-1:0]  hist_count,
  output logic              hist_valid,
  input  logic              hist_ready,
  output logic [CNT_W-1:0]  pix_cnt,
  output logic              hist_done
);

  state_t state, state_n;

  logic [BINS-1:0]   bin_vld;
  logic              finish_d;
  logic              s1_vld;
  logic [CODE_W-1:0] s1_bin;
  logic              byp_vld;
  logic [CODE_W-1:0] byp_bin;
  logic [CNT_W-1:0]  byp_val;
  logic [CODE_W-1:0] rd_idx;

  logic              acc_en;
  logic              accept;
  logic              ram_rd_en;
  logic [CODE_W-1:0] ram_rd_addr;
  logic [CNT_W-1:0]  ram_rdata;
  logic              ram_wr_en;
  logic [CNT_W-1:0]  base;
  logic [CNT_W-1:0]  wdata;

  // Every valid beat is one interior pixel, so the address itself is not needed.
  logic addr_unused;
  assign addr_unused = ^lbp_addr;

  assign acc_en = (state == ACCUM) && lbp_valid && !clear;
  assign accept = hist_valid && hist_ready;

  // Outside ACCUM the read port only fetches the next output bin, and only
  // while no beat is on display, so rdata stays put during a stall.
  assign ram_rd_en   = acc_en || ((state == OUT) && !hist_valid);
  assign ram_rd_addr = acc_en ? lbp_data : rd_idx;
  assign ram_wr_en   = s1_vld && !clear;

  // The bypass covers the previous cycle's write, which the RAM read issued
  // alongside it could not yet see.
  always_comb begin
    base = '0;
    if (byp_vld && (byp_bin == s1_bin)) base = byp_val;
    else if (bin_vld[s1_bin])           base = ram_rdata;
  end

  assign wdata = sat_inc(base);

  lbp_hist_ram u_ram (
    .clk     (clk),
    .rd_en   (ram_rd_en),
    .rd_addr (ram_rd_addr),
    .rdata   (ram_rdata),
    .wr_en   (ram_wr_en),
    .wr_addr (s1_bin),
    .wdata   (wdata)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= ACCUM;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      ACCUM:   if (finish && !finish_d) state_n = DRAIN;
      DRAIN:   state_n = OUT;
      OUT:     if (accept && (rd_idx == CODE_W'(BINS - 1))) state_n = DONE;
      DONE:    state_n = DONE;
      default: state_n = ACCUM;
    endcase
    if (clear) state_n = ACCUM;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bin_vld    <= '0;
      finish_d   <= 1'b0;
      s1_vld     <= 1'b0;
      s1_bin     <= '0;
      byp_vld    <= 1'b0;
      byp_bin    <= '0;
      byp_val    <= '0;
      rd_idx     <= '0;
      pix_cnt    <= '0;
      hist_valid <= 1'b0;
    end else begin
      finish_d <= finish;
      s1_vld   <= acc_en;
      s1_bin   <= lbp_data;
      byp_vld  <= ram_wr_en;
      byp_bin  <= s1_bin;
      byp_val  <= wdata;
      // A beat is raised the cycle after its read and dropped on accept.
      hist_valid <= (state == OUT) && !clear && (!hist_valid || !hist_ready);

      if (clear) begin
        bin_vld <= '0;
        pix_cnt <= '0;
        rd_idx  <= '0;
      end else begin
        if (ram_wr_en) bin_vld[s1_bin] <= 1'b1;
        if (acc_en)    pix_cnt <= sat_inc(pix_cnt);
        if (state == DRAIN) rd_idx <= '0;
        else if (accept)    rd_idx <= rd_idx + 1'b1;
      end
    end
  end

  assign hist_bin   = rd_idx;
  assign hist_count = (hist_valid && bin_vld[rd_idx]) ? ram_rdata : '0;
  assign hist_done  = (state == DONE);

endmodule
